// File: rtl/dbg_cmd_bridge.sv
// System-clock side debug command bridge: edge-detects scan updates, queues {ir, sr} in a FIFO
// and issues them as one-cycle per-channel action pulses. DBG_BRIDGE_STATS_EN adds command/drop counters.
module dbg_cmd_bridge #(
   parameter int DATA_W = 38,
   parameter int IR_W   = 2,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      vs_udr,
   input  logic [IR_W-1:0]           ir_in,
   input  logic [DATA_W-1:0]         sr_in,
   input  logic                      action_ready,
   input  logic                      ovf_clr,
   output logic [DATA_W-1:0]         jdo,
   output logic [(2**IR_W)-1:0]      take_action,
   output logic [(2**IR_W)-1:0]      take_no_action,
   output logic                      cmd_pending,
   output logic [$clog2(DEPTH):0]    level,
`ifdef DBG_BRIDGE_STATS_EN
   output logic [15:0]               cmd_count,
   output logic [15:0]               drop_count,
`endif
   output logic                      ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] sr;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            udr_q;
   logic            push_req;
   logic            pop;
   logic            full;
   logic            push_ok;
   logic            drop;
   logic [LW-1:0]   level_next;

   // A full FIFO still accepts a push when the same cycle pops, since a slot frees up.
   always_comb begin
      push_req   = vs_udr & ~udr_q;
      pop        = cmd_pending & action_ready;
      full       = (level == FULL_LVL);
      push_ok    = push_req & (~full | pop);
      drop       = push_req & full & ~pop;
      head       = mem[rd_ptr];
      level_next = level;
      if (push_ok && !pop)
         level_next = level + LW'(1);
      else if (pop && !push_ok)
         level_next = level - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= '{ir: ir_in, sr: sr_in};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         udr_q          <= 1'b1;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         cmd_pending    <= 1'b0;
         jdo            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         ovf            <= 1'b0;
      end else begin
         udr_q          <= vs_udr;
         level          <= level_next;
         cmd_pending    <= (level_next != '0);
         take_action    <= '0;
         take_no_action <= '0;
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr                  <= rd_ptr + AW'(1);
            jdo                     <= head.sr;
            take_action[head.ir]    <= head.sr[DATA_W-1];
            take_no_action[head.ir] <= ~head.sr[DATA_W-1];
         end
         // A drop in the same cycle as a clear must leave the flag set.
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

`ifdef DBG_BRIDGE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_count  <= '0;
         drop_count <= '0;
      end else begin
         if (pop && cmd_count != 16'hFFFF)
            cmd_count <= cmd_count + 16'd1;
         if (ovf_clr)
            drop_count <= drop ? 16'd1 : 16'd0;
         else if (drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// Self-checking bench for dbg_cmd_bridge: directed scenarios plus a randomized run against
// a queue-based reference model.
module tb_dbg_cmd_bridge;

   localparam int DATA_W = 38;
   localparam int IR_W   = 2;
   localparam int DEPTH  = 4;
   localparam int NCH    = 2**IR_W;

   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] sr;
   } entry_t;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  vs_udr = 1'b0;
   logic [IR_W-1:0]       ir_in = '0;
   logic [DATA_W-1:0]     sr_in = '0;
   logic                  action_ready = 1'b0;
   logic                  ovf_clr = 1'b0;
   logic [DATA_W-1:0]     jdo;
   logic [NCH-1:0]        take_action;
   logic [NCH-1:0]        take_no_action;
   logic                  cmd_pending;
   logic [$clog2(DEPTH):0] level;
   logic                  ovf;
`ifdef DBG_BRIDGE_STATS_EN
   logic [15:0]           cmd_count;
   logic [15:0]           drop_count;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   entry_t            mq[$];
   logic [DATA_W-1:0] m_jdo;
   logic [NCH-1:0]    m_ta;
   logic [NCH-1:0]    m_tna;
   logic              m_ovf;
   logic              m_udr;
   int                m_cmd;
   int                m_drop;

   dbg_cmd_bridge #(.DATA_W(DATA_W), .IR_W(IR_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .vs_udr         (vs_udr),
      .ir_in          (ir_in),
      .sr_in          (sr_in),
      .action_ready   (action_ready),
      .ovf_clr        (ovf_clr),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .cmd_pending    (cmd_pending),
      .level          (level),
`ifdef DBG_BRIDGE_STATS_EN
      .cmd_count      (cmd_count),
      .drop_count     (drop_count),
`endif
      .ovf            (ovf)
   );

   always #5 clk = ~clk;

   // Advance the model by one clock using the inputs currently applied, then clock the DUT.
   task automatic tick();
      entry_t e;
      logic push, pop, dropped;
      if (reset) begin
         mq.delete();
         m_jdo = '0; m_ta = '0; m_tna = '0; m_ovf = 1'b0; m_udr = 1'b1;
         m_cmd = 0; m_drop = 0;
      end else begin
         push    = vs_udr && !m_udr;
         pop     = (mq.size() != 0) && action_ready;
         dropped = 1'b0;
         m_ta    = '0;
         m_tna   = '0;
         if (pop) begin
            e = mq.pop_front();
            m_jdo = e.sr;
            if (e.sr[DATA_W-1]) m_ta[e.ir] = 1'b1;
            else                m_tna[e.ir] = 1'b1;
            if (m_cmd < 65535) m_cmd++;
         end
         if (ovf_clr) m_drop = 0;
         if (push) begin
            if (mq.size() < DEPTH) mq.push_back('{ir: ir_in, sr: sr_in});
            else begin
               dropped = 1'b1;
               if (m_drop < 65535) m_drop++;
            end
         end
         if (dropped) m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         m_udr = vs_udr;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; vs_udr = 1'b0; action_ready = 1'b0; ovf_clr = 1'b0;
      tick(); tick();
      checks++; if (jdo !== '0) begin errors++; $display("[TB] FAIL reset_jdo: got %h expected 0", jdo); end
      checks++; if (take_action !== '0 || take_no_action !== '0) begin errors++; $display("[TB] FAIL reset_pulses: got %b/%b expected 0/0", take_action, take_no_action); end
      checks++; if (cmd_pending !== 1'b0 || level !== '0) begin errors++; $display("[TB] FAIL reset_fifo: got pending %b level %0d expected 0/0", cmd_pending, level); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_action();
      action_ready = 1'b1; ir_in = 2'd2; sr_in = 38'h20000000AB; vs_udr = 1'b1;
      tick();
      checks++; if (level !== 3'd1 || cmd_pending !== 1'b1) begin errors++; $display("[TB] FAIL single_queued: got level %0d pending %b expected 1/1", level, cmd_pending); end
      checks++; if (take_action !== '0) begin errors++; $display("[TB] FAIL single_early: got %b expected 0000", take_action); end
      tick();
      checks++; if (take_action !== 4'b0100 || take_no_action !== 4'b0000) begin errors++; $display("[TB] FAIL single_pulse: got %b/%b expected 0100/0000", take_action, take_no_action); end
      checks++; if (jdo !== 38'h20000000AB) begin errors++; $display("[TB] FAIL single_jdo: got %h expected 20000000ab", jdo); end
      vs_udr = 1'b0; sr_in = '0;
      tick();
      checks++; if (take_action !== '0 || jdo !== 38'h20000000AB || level !== '0) begin errors++; $display("[TB] FAIL single_after: got ta %b jdo %h level %0d expected 0000/20000000ab/0", take_action, jdo, level); end
   endtask

   task automatic test_no_action();
      action_ready = 1'b1; ir_in = 2'd1; sr_in = 38'h0123456789; vs_udr = 1'b1;
      tick();
      vs_udr = 1'b0;
      tick();
      checks++; if (take_no_action !== 4'b0010 || take_action !== 4'b0000) begin errors++; $display("[TB] FAIL noact_pulse: got %b/%b expected 0000/0010", take_action, take_no_action); end
      checks++; if (jdo !== 38'h0123456789) begin errors++; $display("[TB] FAIL noact_jdo: got %h expected 0123456789", jdo); end
      tick();
      checks++; if (take_no_action !== '0) begin errors++; $display("[TB] FAIL noact_one_cycle: got %b expected 0000", take_no_action); end
   endtask

   task automatic test_full();
      logic [DATA_W-1:0] v;
      action_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ir_in = IR_W'(i % NCH); sr_in = {i[0], 37'(i + 16)}; vs_udr = 1'b1;
         tick();
         vs_udr = 1'b0;
         tick();
      end
      checks++; if (level !== 3'd4 || ovf !== 1'b1) begin errors++; $display("[TB] FAIL full_state: got level %0d ovf %b expected 4/1", level, ovf); end
`ifdef DBG_BRIDGE_STATS_EN
      checks++; if (drop_count !== 16'd1) begin errors++; $display("[TB] FAIL full_drop_count: got %0d expected 1", drop_count); end
`endif
      action_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         v = {k[0], 37'(k + 16)};
         checks++;
         if (jdo !== v || take_action !== (k[0] ? NCH'(1 << k) : '0) || take_no_action !== (k[0] ? '0 : NCH'(1 << k))) begin
            errors++; $display("[TB] FAIL full_drain_%0d: got jdo %h ta %b tna %b expected jdo %h", k, jdo, take_action, take_no_action, v);
         end
      end
      tick();
      checks++; if (take_action !== '0 || take_no_action !== '0 || level !== '0) begin errors++; $display("[TB] FAIL full_fifth: got ta %b tna %b level %0d expected 0/0/0", take_action, take_no_action, level); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", ovf); end
   endtask

   task automatic test_full_push_pop();
      action_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ir_in = IR_W'(i); sr_in = DATA_W'(i + 40); vs_udr = 1'b1;
         tick();
         vs_udr = 1'b0;
         tick();
      end
      checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL pp_filled: got %0d expected 4", level); end
      action_ready = 1'b1; ir_in = 2'd3; sr_in = 38'h3F00000044; vs_udr = 1'b1;
      tick();
      checks++; if (level !== 3'd4 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL pp_both: got level %0d ovf %b expected 4/0", level, ovf); end
      checks++; if (jdo !== 38'd40 || take_no_action !== 4'b0001) begin errors++; $display("[TB] FAIL pp_issue: got jdo %h tna %b expected 28/0001", jdo, take_no_action); end
      vs_udr = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (jdo !== 38'h3F00000044 || take_action !== 4'b1000 || level !== '0) begin errors++; $display("[TB] FAIL pp_last: got jdo %h ta %b level %0d expected 3f00000044/1000/0", jdo, take_action, level); end
   endtask

   task automatic test_reset_mid();
      action_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ir_in = IR_W'(i); sr_in = {1'b1, 37'(i + 7)}; vs_udr = 1'b1;
         tick();
         vs_udr = 1'b0;
         tick();
      end
      checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL mid_queued: got %0d expected 3", level); end
      reset = 1'b1; vs_udr = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (jdo !== '0 || take_action !== '0 || take_no_action !== '0 || cmd_pending !== 1'b0 || level !== '0 || ovf !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_reset: got jdo %h ta %b tna %b pend %b level %0d ovf %b expected all 0", jdo, take_action, take_no_action, cmd_pending, level, ovf);
      end
      action_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (take_action !== '0 || take_no_action !== '0 || level !== '0) begin errors++; $display("[TB] FAIL mid_quiet_%0d: got ta %b tna %b level %0d expected 0/0/0", i, take_action, take_no_action, level); end
      end
      vs_udr = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      logic [DATA_W-1:0] seen[$];
      reset = 1'b1; tick(); reset = 1'b0; tick();
      action_ready = 1'b1;
      for (int v = 1; v <= 10; v++) begin
         ir_in = IR_W'(v % NCH); sr_in = DATA_W'(v); vs_udr = 1'b1;
         tick();
         vs_udr = 1'b0;
         tick();
         if ((take_action | take_no_action) != '0) seen.push_back(jdo);
      end
      checks++; if (seen.size() != 10) begin errors++; $display("[TB] FAIL wrap_count: got %0d issues expected 10", seen.size()); end
      for (int i = 0; i < seen.size(); i++) begin
         checks++; if (seen[i] !== DATA_W'(i + 1)) begin errors++; $display("[TB] FAIL wrap_seq_%0d: got %0d expected %0d", i, seen[i], i + 1); end
      end
      checks++; if (ovf !== 1'b0 || level !== '0) begin errors++; $display("[TB] FAIL wrap_end: got ovf %b level %0d expected 0/0", ovf, level); end
`ifdef DBG_BRIDGE_STATS_EN
      checks++; if (cmd_count !== 16'd10) begin errors++; $display("[TB] FAIL wrap_cmd_count: got %0d expected 10", cmd_count); end
`endif
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         vs_udr       = ($urandom_range(0, 99) < 50);
         action_ready = ($urandom_range(0, 99) < 45);
         ovf_clr      = ($urandom_range(0, 99) < 5);
         ir_in        = IR_W'($urandom);
         sr_in        = {6'($urandom), 32'($urandom)};
         tick();
         checks++;
         if (jdo !== m_jdo || take_action !== m_ta || take_no_action !== m_tna ||
             cmd_pending !== (mq.size() != 0) || level !== ($clog2(DEPTH)+1)'(mq.size()) || ovf !== m_ovf) begin
            errors++;
            $display("[TB] FAIL random_%0d: got jdo %h ta %b tna %b pend %b level %0d ovf %b expected jdo %h ta %b tna %b level %0d ovf %b",
                     c, jdo, take_action, take_no_action, cmd_pending, level, ovf, m_jdo, m_ta, m_tna, mq.size(), m_ovf);
         end
`ifdef DBG_BRIDGE_STATS_EN
         checks++;
         if (cmd_count !== 16'(m_cmd) || drop_count !== 16'(m_drop)) begin
            errors++; $display("[TB] FAIL random_stats_%0d: got %0d/%0d expected %0d/%0d", c, cmd_count, drop_count, m_cmd, m_drop);
         end
`endif
      end
      vs_udr = 1'b0; ovf_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_action();
      test_no_action();
      test_full();
      test_full_push_pop();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/dbg_cmd_bridge.md
# dbg_cmd_bridge

Parametrised system-clock-side command bridge for the Nios II JTAG debug path. It captures debug-scan updates (instruction register plus shift-register word, already synchronised into `clk`) and buffers them in a small command FIFO. It then drains them under back-pressure as one-cycle per-instruction action pulses with a held data word. This block replaces the fixed 2-bit-IR, unbuffered sysclk decoder, adding configurable IR width, configurable data width, queueing, overflow tracking and flow control toward the OCI logic.

## Interface
- `DATA_W`, 38, width of the scan data word (`sr_in`, `jdo`); MSB is the action bit.
- `IR_W`, 2, instruction register width; 2**IR_W action channels.
- `DEPTH`, 4, command FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `vs_udr`  in  1  update-DR level, synchronised to `clk`; rising edge = new command.
- `ir_in`  in  IR_W  instruction register value, stable while `vs_udr` high.
- `sr_in`  in  DATA_W  scan word, stable while `vs_udr` high.
- `action_ready`  in  1  downstream may accept a command this cycle.
- `ovf_clr`  in  1  clears `ovf` sticky flag.
- `jdo`  out  DATA_W  data word of last issued command.
- `take_action`  out  2**IR_W  one-hot pulse, channel = issued IR, action bit = 1.
- `take_no_action`  out  2**IR_W  one-hot pulse, channel = issued IR, action bit = 0.
- `cmd_pending`  out  1  FIFO non-empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `ovf`  out  1  sticky: a command was dropped on full FIFO.

## Operation
- Edge detect: register `udr_q <= vs_udr`. A push request occurs in the cycle where `vs_udr=1 && udr_q=0`. A held-high `vs_udr` produces exactly one push.
- Push writes `{ir_in, sr_in}` at write pointer; pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Occupancy is a separate counter 0..DEPTH.
- Pop occurs when `cmd_pending && action_ready`. The popped entry drives the registered outputs on the next cycle:
  - `jdo <= entry.sr`;
  - `take_action[entry.ir] <= entry.sr[DATA_W-1]`;
  - `take_no_action[entry.ir] <= !entry.sr[DATA_W-1]`.
  - All other pulse bits are 0.
- Pulses last exactly one cycle. `jdo` holds until the next pop.
- Full and push with no pop: command dropped, `ovf` set, `level` unchanged.
- Full and push with pop in the same cycle: both occur, `level` stays DEPTH, and no overflow is flagged.
- Empty and push in the same cycle: no pop that cycle, because `cmd_pending` is registered. The entry is poppable from the next cycle.
- `ovf_clr` and overflow in the same cycle: set wins.
- Reset mid-operation discards all queued entries. Nothing is issued after reset until a new edge arrives. `udr_q` resets to 1, so a `vs_udr` already high at reset release does not push.

## Timing
- Reset values: `jdo`=0, `take_action`=0, `take_no_action`=0, `cmd_pending`=0, `level`=0, `ovf`=0, pointers=0, `udr_q`=1.
- Edge in cycle N → `cmd_pending`=1 and `level` incremented in N+1.
- With `action_ready` high, pop in N+1 → pulse and `jdo` valid in N+2. Minimum latency is 2 cycles from the edge.
- Throughput: one issue per cycle while non-empty and `action_ready`=1.
- `action_ready` low stalls indefinitely; no entry is lost.

## Configuration
- `DBG_BRIDGE_STATS_EN` defined: adds outputs `cmd_count` [15:0] and `drop_count` [15:0].
  - `cmd_count` increments on each issued command.
  - `drop_count` increments on each dropped push.
  - Both saturate at 16'hFFFF and reset to 0.
  - `ovf_clr` also zeroes `drop_count`.
- Not defined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Single command: IR=2, `sr_in`=38'h2_0000_00AB (action bit 1), `action_ready`=1 → `take_action`=4'b0100 for one cycle at edge+2, `jdo`=38'h2_0000_00AB held, `level` returns to 0.
- No-action: IR=1, MSB=0 → `take_no_action`=4'b0010 for one cycle, `take_action`=0.
- Back-pressure/full: `action_ready`=0, 5 edges with DEPTH=4 → `level`=4, `ovf`=1, `drop_count`=1. Raise ready → 4 pulses on consecutive cycles in push order, 5th absent.
- Full with simultaneous push and pop: `level`=4, ready=1 and edge in the same cycle → `level` stays 4, `ovf` stays 0.
- Reset mid-queue: 3 entries queued, `reset` pulsed 1 cycle → all outputs 0 next cycle. With `vs_udr` held high through release, no pulse occurs.
- Wrap-around: 10 push/pop pairs, DEPTH=4, distinct `sr` values 1..10 → issued `jdo` sequence 1..10 exactly, `ovf`=0, `cmd_count`=10.
